// File: rtl/store_queue_mp.sv
// Store queue with in-order allocate/retire/drain and per-byte store-to-load forwarding on NUM_LD ports.
// Optional macro SQ_PERF_CNT_EN adds saturating forwarded-byte and drain-stall counters.
module store_queue_mp #(
  parameter  int DEPTH  = 16,
  parameter  int DISP_W = 2,
  parameter  int RET_W  = 2,
  parameter  int NUM_LD = 2,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int PTR_W  = IDX_W + 1,
  localparam int DC_W   = $clog2(DISP_W + 1),
  localparam int RC_W   = $clog2(RET_W + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DC_W-1:0]         disp_count,
  output logic [PTR_W-1:0]        sq_tail,
  output logic [DC_W-1:0]         sq_free,
  output logic                    sq_empty,
  input  logic                    res_valid,
  input  logic [IDX_W-1:0]        res_idx,
  input  logic [31:0]             res_addr,
  input  logic [31:0]             res_data,
  input  logic [3:0]              res_bmask,
  input  logic [NUM_LD*PTR_W-1:0] ld_sq_tail,
  input  logic [NUM_LD*32-1:0]    ld_addr,
  output logic [NUM_LD*32-1:0]    ld_fwd_data,
  output logic [NUM_LD*4-1:0]     ld_fwd_mask,
  output logic [NUM_LD-1:0]       ld_unresolved,
  input  logic                    restore_valid,
  input  logic [PTR_W-1:0]        restore_tail,
  input  logic [RC_W-1:0]         retire_count,
  output logic                    drain_valid,
  output logic [31:0]             drain_addr,
  output logic [31:0]             drain_data,
  output logic [3:0]              drain_bmask,
  input  logic                    drain_accept
`ifdef SQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fwd_bytes,
  output logic [31:0]             perf_drain_stall
`endif
);

  typedef enum logic [1:0] {ST_FREE, ST_ALLOC, ST_RESOLVED, ST_COMMITTED} ent_state_t;

  ent_state_t       state_q [DEPTH];
  ent_state_t       state_d [DEPTH];
  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [3:0]       bmask_q [DEPTH];

  logic [PTR_W-1:0] head_q, commit_q, tail_q;
  logic [PTR_W-1:0] head_d, commit_d, tail_d;
  logic [PTR_W-1:0] occ, free_cnt, squash_n;
  logic             drain_fire;

  assign occ      = tail_q - head_q;
  assign free_cnt = PTR_W'(DEPTH) - occ;
  assign squash_n = tail_q - restore_tail;
  assign sq_tail  = tail_q;
  assign sq_empty = (occ == '0);
  assign sq_free  = (free_cnt >= PTR_W'(DISP_W)) ? DC_W'(DISP_W) : DC_W'(free_cnt);

  // Drain handshake: drain_valid is high while the head entry is COMMITTED and its payload
  // holds stable; one store transfers on each cycle where drain_valid and drain_accept are both high.
  assign drain_valid = (state_q[head_q[IDX_W-1:0]] == ST_COMMITTED);
  assign drain_addr  = addr_q[head_q[IDX_W-1:0]];
  assign drain_data  = data_q[head_q[IDX_W-1:0]];
  assign drain_bmask = bmask_q[head_q[IDX_W-1:0]];
  assign drain_fire  = drain_valid & drain_accept;

  logic [IDX_W-1:0] e_idx, off_tail, off_commit, off_rest;

  // Later rules override earlier ones, so a restore squash beats a resolve into the same entry.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q + PTR_W'(drain_fire);
    commit_d   = commit_q + PTR_W'(retire_count);
    tail_d     = restore_valid ? restore_tail : tail_q + PTR_W'(disp_count);
    e_idx      = '0;
    off_tail   = '0;
    off_commit = '0;
    off_rest   = '0;
    for (int e = 0; e < DEPTH; e++) begin
      e_idx      = IDX_W'(e);
      off_tail   = e_idx - tail_q[IDX_W-1:0];
      off_commit = e_idx - commit_q[IDX_W-1:0];
      off_rest   = e_idx - restore_tail[IDX_W-1:0];
      if (res_valid && res_idx == e_idx && state_q[e] == ST_ALLOC) state_d[e] = ST_RESOLVED;
      if (PTR_W'(off_commit) < PTR_W'(retire_count)) state_d[e] = ST_COMMITTED;
      if (drain_fire && e_idx == head_q[IDX_W-1:0]) state_d[e] = ST_FREE;
      if (!restore_valid && PTR_W'(off_tail) < PTR_W'(disp_count)) state_d[e] = ST_ALLOC;
      if (restore_valid && PTR_W'(off_rest) < squash_n) state_d[e] = ST_FREE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      for (int e = 0; e < DEPTH; e++) state_q[e] <= ST_FREE;
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      for (int e = 0; e < DEPTH; e++) state_q[e] <= state_d[e];
    end
  end

  // Payload is qualified by entry state, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (res_valid && res_idx == IDX_W'(e) && state_q[e] == ST_ALLOC) begin
        addr_q[e]  <= res_addr;
        data_q[e]  <= res_data;
        bmask_q[e] <= res_bmask;
      end
    end
  end

  logic [PTR_W-1:0] f_lt, f_n, f_kp;
  logic [IDX_W-1:0] f_ki;
  logic [31:0]      f_la;

  // Walk oldest to youngest so the youngest matching store ends up owning each lane.
  always_comb begin
    ld_fwd_data   = '0;
    ld_fwd_mask   = '0;
    ld_unresolved = '0;
    f_lt = '0;
    f_n  = '0;
    f_kp = '0;
    f_ki = '0;
    f_la = '0;
    for (int p = 0; p < NUM_LD; p++) begin
      f_lt = ld_sq_tail[p*PTR_W +: PTR_W];
      f_la = ld_addr[p*32 +: 32];
      f_n  = f_lt - head_q;
      for (int k = 0; k < DEPTH; k++) begin
        f_kp = head_q + PTR_W'(k);
        f_ki = f_kp[IDX_W-1:0];
        if (PTR_W'(k) < f_n) begin
          if (state_q[f_ki] == ST_ALLOC) ld_unresolved[p] = 1'b1;
          if ((state_q[f_ki] == ST_RESOLVED || state_q[f_ki] == ST_COMMITTED) &&
              addr_q[f_ki][31:2] == f_la[31:2]) begin
            for (int b = 0; b < 4; b++) begin
              if (bmask_q[f_ki][b]) begin
                ld_fwd_data[p*32 + b*8 +: 8] = data_q[f_ki][b*8 +: 8];
                ld_fwd_mask[p*4 + b]         = 1'b1;
              end
            end
          end
        end
      end
    end
  end

`ifdef SQ_PERF_CNT_EN
  localparam int PC_W = $clog2(NUM_LD*4 + 1);
  logic [PC_W-1:0] fwd_pop;
  logic [32:0]     fwd_sum;

  always_comb begin
    fwd_pop = '0;
    for (int i = 0; i < NUM_LD*4; i++) fwd_pop = fwd_pop + PC_W'(ld_fwd_mask[i]);
  end
  assign fwd_sum = {1'b0, perf_fwd_bytes} + 33'(fwd_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fwd_bytes   <= '0;
      perf_drain_stall <= '0;
    end else begin
      perf_fwd_bytes <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      if (drain_valid && !drain_accept && perf_drain_stall != '1)
        perf_drain_stall <= perf_drain_stall + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  logic             retire_ok;
  logic [IDX_W-1:0] ret_idx;
  always_comb begin
    retire_ok = 1'b1;
    ret_idx   = '0;
    for (int i = 0; i < RET_W; i++) begin
      ret_idx = commit_q[IDX_W-1:0] + IDX_W'(i);
      if (i < int'(retire_count) && state_q[ret_idx] != ST_RESOLVED) retire_ok = 1'b0;
    end
  end

  a_disp_fits: assert property (@(posedge clock) disable iff (reset) disp_count <= sq_free);
  a_retire_resolved: assert property (@(posedge clock) disable iff (reset) retire_ok);
  a_restore_range: assert property (@(posedge clock) disable iff (reset)
    restore_valid |-> (PTR_W'(restore_tail - commit_q) <= PTR_W'(tail_q - commit_q)));
`endif

endmodule

// File: doc/store_queue_mp.md
Name: store_queue_mp

Overview:
Parametrised multi-load-port store queue for the out-of-order core. It allocates store entries in program order at dispatch and captures resolved address/data from the store unit. Retire marks entries committed; committed stores drain to the D-cache over a valid/accept handshake. Every load port gets per-byte store-to-load forwarding, plus a flag when an older store address is still unknown. Branch-stack restore reclaims squashed entries.

Parameters:
DEPTH, 16, entry count; power of two, ≥2; IDX_W=$clog2(DEPTH), PTR_W=IDX_W+1 (MSB = wrap parity)
DISP_W, 2, max stores allocated per cycle
RET_W, 2, max stores committed per cycle
NUM_LD, 2, load forwarding ports

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
disp_count  in  $clog2(DISP_W+1)  stores allocating this cycle, at tail upward
sq_tail  out  PTR_W  next allocation pointer
sq_free  out  $clog2(DISP_W+1)  min(DISP_W, free entries)
sq_empty  out  1  no entries in any state
res_valid  in  1  store resolve strobe
res_idx  in  IDX_W  entry being resolved
res_addr  in  32  byte address
res_data  in  32  lane-aligned data
res_bmask  in  4  byte enables
ld_sq_tail  in  NUM_LD*PTR_W  per port: sq_tail captured at load dispatch
ld_addr  in  NUM_LD*32  per port load address
ld_fwd_data  out  NUM_LD*32  forwarded bytes; unforwarded lanes 0
ld_fwd_mask  out  NUM_LD*4  lanes forwarded
ld_unresolved  out  NUM_LD  an older entry still lacks an address
restore_valid  in  1  mispredict restore
restore_tail  in  PTR_W  tail to restore
retire_count  in  $clog2(RET_W+1)  stores committing this cycle
drain_valid  out  1  head entry committed, request to D-cache
drain_addr  out  32  head address
drain_data  out  32  head data
drain_bmask  out  4  head byte mask
drain_accept  in  1  D-cache accepts head this cycle

Behaviour:
- Per-entry state: FREE, ALLOC (no address), RESOLVED, COMMITTED. Pointers: head (oldest, drain), commit (next to retire), tail. All pointers are PTR_W wide; full when indices are equal and parities differ.
- Reset: all entries FREE, all pointers 0, sq_free=min(DISP_W,DEPTH), sq_empty=1, drain_valid=0, forwarding outputs 0.
- Dispatch: disp_count entries at tail become ALLOC; tail+=disp_count next cycle. disp_count>sq_free is illegal (assertion).
- Resolve: the ALLOC entry at res_idx latches addr/data/bmask and becomes RESOLVED next cycle. Resolve to a non-ALLOC entry is ignored.
- Retire: retire_count entries from commit go RESOLVED→COMMITTED; commit+=retire_count. A non-RESOLVED entry in the retire range is illegal (assertion).
- Drain: drain_valid=1 iff entry[head] is COMMITTED; outputs come straight from that entry. drain_valid & drain_accept frees the entry and head+=1 next cycle. Outputs hold stable while unaccepted.
- Restore: tail←restore_tail; entries from restore_tail up to the old tail become FREE. Restore has priority over dispatch (dispatch dropped) and over a same-cycle resolve into a squashed entry. restore_tail must lie in [commit, tail] (assertion). Retire and drain proceed normally in the same cycle.
- sq_free uses the registered occupancy ((tail-head) mod 2^PTR_W), so it is one cycle conservative on drains.
- Forwarding (combinational, per port and per byte lane): the candidate range is [head, ld_sq_tail). Match requires addr[31:2] equal, bmask lane set, and state RESOLVED or COMMITTED. The youngest match in age order wins, with wrap handled via pointer parity. An empty range gives no match. ld_unresolved=1 if any ALLOC entry lies in range.
- Same-cycle resolve/drain effects are not seen by forwarding; registered state only. An entry draining this cycle still forwards.

Optional Feature:
SQ_PERF_CNT_EN: adds outputs perf_fwd_bytes (32b), which each cycle accumulates the popcount of all ld_fwd_mask bits, and perf_drain_stall (32b), which counts cycles with drain_valid & ~drain_accept. Both clear on reset and saturate at all-ones. Without the macro these ports and counters do not exist.

Test Plan:
- Reset → sq_tail=0, sq_free=2, sq_empty=1, drain_valid=0.
- Dispatch 2; resolve idx0 addr 0x1000 data 0xAABBCCDD bmask 0xF; load port0 ld_sq_tail=2, addr 0x1000 → fwd_mask=0xF, data 0xAABBCCDD, ld_unresolved=1 (idx1 ALLOC).
- idx0 addr 0x2000 bmask 0xF data 0x11111111, idx1 addr 0x2000 bmask 0x3 data 0x00002222, load 0x2000 tail=2 → data 0x11112222, mask 0xF.
- Retire 1, drain_accept low 3 cycles → drain_valid held with addr 0x1000 stable; accept → head=1 next cycle.
- Fill DEPTH=16 through wrap (tail parity flips) → sq_free=0; drain one → sq_free=1 the following cycle.
- Dispatch 4 (tail 4), restore_tail=2 while disp_count=2 and resolve idx3 → tail=2, idx2/3 FREE, dispatch dropped.
